multi_port_memory: RTL

- Parametrised successor to the single-channel CPU memory: one synchronous RAM shared by PORTS requesters.
- Each requester uses the same start/ready handshake.
- A round-robin arbiter serialises accesses; WAIT_STATES adds programmable access latency.
- Sits between the CPU plus other bus masters (video, DMA) and block RAM.

---
 rtl/memory_pkg.sv | 21 ++
 rtl/round_robin_arbiter.sv | 29 ++
 rtl/multi_port_memory.sv | 163 ++++++++++++++++
 3 files changed

// File: rtl/memory_pkg.sv
// Shared definitions for the multi-port memory: FSM encoding, direction codes,
// wait-counter width and a helper for port-index widths.
package memory_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

   localparam logic DIR_READ  = 1'b0;
   localparam logic DIR_WRITE = 1'b1;

   localparam int WAIT_W = 4;

   // A single-port build still needs a one-bit index.
   function automatic int idx_width(input int ports);
      return (ports > 1) ? $clog2(ports) : 1;
   endfunction

endpackage

// File: rtl/round_robin_arbiter.sv
// Combinational round-robin picker: first requesting port at or after the
// pointer, wrapping modulo PORTS. The pointer register lives in the parent.
module round_robin_arbiter
   import memory_pkg::*;
#(
   parameter int PORTS = 2,
   parameter int IDX_W = idx_width(PORTS)
) (
   input  logic [PORTS-1:0] request,
   input  logic [IDX_W-1:0] pointer,
   output logic [PORTS-1:0] grant,
   output logic [IDX_W-1:0] grant_index,
   output logic             valid
);

   always_comb begin
      grant       = '0;
      grant_index = '0;
      valid       = 1'b0;
      for (int i = 0; i < PORTS; i++) begin
         if (!valid && request[(int'(pointer) + i) % PORTS]) begin
            valid                                 = 1'b1;
            grant[(int'(pointer) + i) % PORTS]    = 1'b1;
            grant_index = IDX_W'((int'(pointer) + i) % PORTS);
         end
      end
   end

endmodule

// File: rtl/multi_port_memory.sv
// PORTS requesters sharing one synchronous RAM through a round-robin arbiter
// with WAIT_STATES extra cycles per access. Optional per-port access counters
// are enabled with MULTI_PORT_MEMORY_ACCESS_COUNTER_EN.
module multi_port_memory
   import memory_pkg::*;
#(
   parameter int ADDRESS_WIDTH = 16,
   parameter int DATA_WIDTH    = 8,
   parameter int PORTS         = 2,
   parameter int WAIT_STATES   = 2
) (
   input  logic                           clock,
   input  logic                           reset_n,
   input  logic [PORTS*ADDRESS_WIDTH-1:0] address,
   input  logic [PORTS*DATA_WIDTH-1:0]    data_in,
   input  logic [PORTS-1:0]               direction,
   input  logic [PORTS-1:0]               start,
   output logic [PORTS*DATA_WIDTH-1:0]    data_out,
   output logic [PORTS-1:0]               ready,
   output logic [PORTS-1:0]               busy
`ifdef MULTI_PORT_MEMORY_ACCESS_COUNTER_EN
   ,
   output logic [PORTS*16-1:0]            access_count
`endif
);

   localparam int IDX_W = idx_width(PORTS);

   state_t                   state, state_nxt;
   logic [WAIT_W-1:0]        wait_cnt;
   logic [IDX_W-1:0]         rr_ptr;
   logic [IDX_W-1:0]         cur_port;
   logic [PORTS-1:0]         cur_onehot;
   logic [PORTS-1:0]         start_q;
   logic [PORTS-1:0]         pending;
   logic [PORTS-1:0]         busy_r;
   logic [PORTS-1:0]         ready_r;
   logic [PORTS-1:0]         accept;
   logic                     commit;

   logic [ADDRESS_WIDTH-1:0] req_addr [PORTS];
   logic [DATA_WIDTH-1:0]    req_data [PORTS];
   logic [PORTS-1:0]         req_dir;

   logic [DATA_WIDTH-1:0]    mem [2**ADDRESS_WIDTH];
   logic [DATA_WIDTH-1:0]    rd_word;

   logic [PORTS-1:0]         arb_grant;
   logic [IDX_W-1:0]         arb_idx;
   logic                     arb_valid;

   // A rising start is only honoured on a port that is not already busy.
   assign accept = start & ~start_q & ~busy_r;
   assign commit = (state == ACCESS) && (wait_cnt == '0);
   assign rd_word = mem[req_addr[cur_port]];

   round_robin_arbiter #(
      .PORTS (PORTS),
      .IDX_W (IDX_W)
   ) u_arbiter (
      .request     (pending),
      .pointer     (rr_ptr),
      .grant       (arb_grant),
      .grant_index (arb_idx),
      .valid       (arb_valid)
   );

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         start_q <= '0;
         pending <= '0;
         busy_r  <= '0;
      end else begin
         start_q <= start;
         pending <= (pending | accept) & ~(commit ? cur_onehot : '0);
         busy_r  <= (busy_r | accept) & ~((state == DONE) ? cur_onehot : '0);
      end
   end

   always_ff @(posedge clock) begin
      for (int p = 0; p < PORTS; p++) begin
         if (accept[p]) begin
            req_addr[p] <= address[p*ADDRESS_WIDTH +: ADDRESS_WIDTH];
            req_data[p] <= data_in[p*DATA_WIDTH +: DATA_WIDTH];
            req_dir[p]  <= direction[p];
         end
      end
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (arb_valid) state_nxt = ACCESS;
         ACCESS:  if (wait_cnt == '0) state_nxt = DONE;
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state      <= IDLE;
         wait_cnt   <= '0;
         rr_ptr     <= '0;
         cur_port   <= '0;
         cur_onehot <= '0;
         ready_r    <= '0;
      end else begin
         state   <= state_nxt;
         ready_r <= '0;
         case (state)
            IDLE: begin
               if (arb_valid) begin
                  cur_port   <= arb_idx;
                  cur_onehot <= arb_grant;
                  wait_cnt   <= WAIT_W'(WAIT_STATES);
                  if (arb_idx == IDX_W'(PORTS - 1)) rr_ptr <= '0;
                  else                              rr_ptr <= arb_idx + 1'b1;
               end
            end
            ACCESS: begin
               if (wait_cnt != '0) wait_cnt <= wait_cnt - 1'b1;
               else                ready_r  <= cur_onehot;
            end
            default: ;
         endcase
      end
   end

   // RAM has no reset; commit is gated by the reset-controlled FSM state.
   always_ff @(posedge clock) begin
      if (commit && req_dir[cur_port] == DIR_WRITE)
         mem[req_addr[cur_port]] <= req_data[cur_port];
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         data_out <= '0;
      end else if (commit && req_dir[cur_port] == DIR_READ) begin
         data_out[cur_port*DATA_WIDTH +: DATA_WIDTH] <= rd_word;
      end
   end

   assign ready = ready_r;
   assign busy  = busy_r;

`ifdef MULTI_PORT_MEMORY_ACCESS_COUNTER_EN
   logic [15:0] acc_cnt [PORTS];

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         for (int p = 0; p < PORTS; p++) acc_cnt[p] <= '0;
      end else if (state == DONE) begin
         acc_cnt[cur_port] <= acc_cnt[cur_port] + 16'd1;
      end
   end

   for (genvar p = 0; p < PORTS; p++) begin : g_cnt
      assign access_count[p*16 +: 16] = acc_cnt[p];
   end
`endif

endmodule
